aes_encrypt_iterative: RTL

- Iterative, handshaked AES-128 encryption core. It performs one cipher round per clock, using the team's existing round datapath (sub_byte, shift_row, mix_columns, add_round_key).
- Successor to the single-shot combinational encryption block. It adds a parametrised round count, on-the-fly key expansion, a proper final round without MixColumns, and valid/ready flow control at both ends.
- Sits between the block-input buffer and the ciphertext output stage. One block is in flight at a time.

---
 rtl/aes_encrypt_iterative.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/aes_encrypt_iterative.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : aes_encrypt_iterative
// Brief   : Iterative AES-128 encryptor, one round per clock, valid/ready on
//           both sides. Macro AES_BACK_TO_BACK_EN lets DONE accept a new block.
// Rev     : 1.0  initial release
// ============================================================================
module aes_encrypt_iterative #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] inputData,
  input  logic [127:0] key,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outputData,
  output logic         busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  generate
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_num_rounds
      $error("aes_encrypt_iterative: NUM_ROUNDS must be in 1..10");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    gmul = p;
  endfunction

  // S-box computed as the GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    inv  = gmul(gmul(x240, x12), x2);
    sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte i of the state lives at [127-8i -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    sub_shift = o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                                ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
    end
    mix_columns = o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64]  ^ n0;
    n2 = rk[63:32]  ^ n1;
    n3 = rk[31:0]   ^ n2;
    expand_key = {n0, n1, n2, n3};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] data_q, data_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] w_next_key, w_sub_shift;
  logic         w_last, w_load;

  assign w_next_key  = expand_key(rk_q, rcon(round_q));
  assign w_sub_shift = sub_shift(data_q);
  assign w_last      = (round_q == LAST_ROUND);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    data_d  = data_q;
    rk_d    = rk_q;
    w_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inValid) w_load = 1'b1;
      end
      S_ROUND: begin
        data_d = (w_last ? w_sub_shift : mix_columns(w_sub_shift)) ^ w_next_key;
        rk_d   = w_next_key;
        if (w_last) state_d = S_DONE;
        else        round_d = round_q + 4'd1;
      end
      S_DONE: begin
        if (outReady) begin
          state_d = S_IDLE;
`ifdef AES_BACK_TO_BACK_EN
          if (inValid) w_load = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_load) begin
      data_d  = inputData ^ key;
      rk_d    = key;
      round_d = 4'd1;
      state_d = S_ROUND;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      data_q  <= '0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
      rk_q    <= rk_d;
    end
  end

`ifdef AES_BACK_TO_BACK_EN
  assign inReady = nReset & ((state_q == S_IDLE) | ((state_q == S_DONE) & outReady));
`else
  assign inReady = nReset & (state_q == S_IDLE);
`endif
  assign outValid   = (state_q == S_DONE);
  assign busy       = (state_q == S_ROUND);
  assign outputData = outValid ? data_q : '0;

endmodule
`default_nettype wire
